register_bank_sb: RTL and testbench

- Parametrised successor to the 16x32 register bank: generic width and depth, two registered read ports, and a write enable.
- Adds a per-register pending scoreboard: an issue stage reserves a destination, and a writeback clears the reservation.
- Read ports report whether each source is still pending, so the pipeline control can stall on hazards.
- Sits between decode/issue (read and reserve) and writeback (write), feeding the ALU and memory control.

---
 rtl/register_bank_pkg.sv | 20 ++
 rtl/register_bank_scoreboard.sv | 45 ++++
 rtl/register_bank_sb.sv | 86 ++++++++
 tb/tb_register_bank_sb.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared constants, helpers and types for the register bank
package register_bank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2_depth(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

  localparam int DEF_ADDR_W = clog2_depth(DEF_DEPTH);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_bank_scoreboard.sv
// rtl/register_bank_scoreboard.sv - per-register pending bits with reserve-over-clear precedence
// Exposes the next-state pending vector and its popcount so the top can register them.
module register_bank_scoreboard
  import register_bank_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = clog2_depth(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  pend_d,
  output logic [ADDR_W:0]   cnt_d
);

  logic [DEPTH-1:0] pend_q;
  logic             rsv_ok;
  logic             clr_ok;

  always_comb begin
    rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
    clr_ok = clr_en && !(ZERO_REG != 0 && clr_addr == '0);
    pend_d = pend_q;
    // Reserve applied last: a same-cycle reservation belongs to a newer producer.
    if (clr_ok) pend_d[clr_addr] = 1'b0;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/register_bank_sb.sv
// rtl/register_bank_sb.sv - parametrised register bank with two registered read ports and a pending scoreboard
// Reads are write-first: data and busy come from the next-state array and pending vector.
module register_bank_sb
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = clog2_depth(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic              rbusy1_q, rbusy1_d;
  logic              rbusy2_q, rbusy2_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
  logic [DEPTH-1:0]  pend_d;
  logic              we_ok;

  register_bank_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_en   (we),
    .clr_addr (waddr),
    .pend_d   (pend_d),
    .cnt_d    (pend_cnt_d)
  );

  // With ZERO_REG, r0 never gets written or reserved, so the next-state view reads 0/0 there.
  always_comb begin
    we_ok  = we && !(ZERO_REG != 0 && waddr == '0);
    regs_d = regs_q;
    if (we_ok) regs_d[waddr] = wdata;
    rdata1_d = regs_d[raddr1];
    rdata2_d = regs_d[raddr2];
    rbusy1_d = pend_d[raddr1];
    rbusy2_d = pend_d[raddr2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      rbusy1_q   <= 1'b0;
      rbusy2_q   <= 1'b0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      rbusy1_q   <= rbusy1_d;
      rbusy2_q   <= rbusy2_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign rdata1   = rdata1_q;
  assign rdata2   = rdata2_q;
  assign rbusy1   = rbusy1_q;
  assign rbusy2   = rbusy2_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_register_bank_sb.sv
// tb/tb_register_bank_sb.sv - directed and random checks of register_bank_sb against a behavioural model
module tb_register_bank_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic [3:0]  raddr1;
  logic [3:0]  raddr2;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        rb1_0, rb2_0, rb1_1, rb2_1;
  logic [4:0]  cnt_0, cnt_1;

  int vectors;
  int miscompares;

  logic [31:0] m_regs [2][16];
  logic        m_pend [2][16];
  logic [31:0] e_rd1 [2];
  logic [31:0] e_rd2 [2];
  logic        e_b1 [2];
  logic        e_b2 [2];
  int          e_cnt [2];

  register_bank_sb #(.DATA_W(32), .DEPTH(16), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_0), .rdata2(rd2_0), .rbusy1(rb1_0), .rbusy2(rb2_0), .pend_cnt(cnt_0)
  );

  register_bank_sb #(.DATA_W(32), .DEPTH(16), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_1), .rdata2(rd2_1), .rbusy1(rb1_1), .rbusy2(rb2_1), .pend_cnt(cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[z][i] = '0;
        m_pend[z][i] = 1'b0;
      end
      e_rd1[z] = '0;
      e_rd2[z] = '0;
      e_b1[z]  = 1'b0;
      e_b2[z]  = 1'b0;
      e_cnt[z] = 0;
    end
  endtask

  // Architectural rules: write lands and clears, then reserve sets; reads see the result.
  task automatic model_step();
    for (int z = 0; z < 2; z++) begin
      if (we && !(z == 1 && waddr == 0)) begin
        m_regs[z][waddr] = wdata;
        m_pend[z][waddr] = 1'b0;
      end
      if (rsv_en && !(z == 1 && rsv_addr == 0)) m_pend[z][rsv_addr] = 1'b1;
      e_rd1[z] = (z == 1 && raddr1 == 0) ? 32'd0 : m_regs[z][raddr1];
      e_rd2[z] = (z == 1 && raddr2 == 0) ? 32'd0 : m_regs[z][raddr2];
      e_b1[z]  = (z == 1 && raddr1 == 0) ? 1'b0 : m_pend[z][raddr1];
      e_b2[z]  = (z == 1 && raddr2 == 0) ? 1'b0 : m_pend[z][raddr2];
      e_cnt[z] = 0;
      for (int i = 0; i < 16; i++) e_cnt[z] += int'(m_pend[z][i]);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".z0.rdata1"}, rd1_0, e_rd1[0]);
    chk({tag, ".z0.rdata2"}, rd2_0, e_rd2[0]);
    chk({tag, ".z0.rbusy1"}, 32'(rb1_0), 32'(e_b1[0]));
    chk({tag, ".z0.rbusy2"}, 32'(rb2_0), 32'(e_b2[0]));
    chk({tag, ".z0.pend_cnt"}, 32'(cnt_0), 32'(e_cnt[0]));
    chk({tag, ".z1.rdata1"}, rd1_1, e_rd1[1]);
    chk({tag, ".z1.rdata2"}, rd2_1, e_rd2[1]);
    chk({tag, ".z1.rbusy1"}, 32'(rb1_1), 32'(e_b1[1]));
    chk({tag, ".z1.rbusy2"}, 32'(rb2_1), 32'(e_b2[1]));
    chk({tag, ".z1.pend_cnt"}, 32'(cnt_1), 32'(e_cnt[1]));
  endtask

  task automatic step(input string tag, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                      input logic r, input logic [3:0] ra, input logic [3:0] a1, input logic [3:0] a2);
    we = w; waddr = wa; wdata = wd;
    rsv_en = r; rsv_addr = ra;
    raddr1 = a1; raddr2 = a2;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] wa, ra, a1, a2;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    we = 0; waddr = 0; wdata = 0; rsv_en = 0; rsv_addr = 0; raddr1 = 0; raddr2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    step("seed", 1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd7, 4'd5, 4'd7);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("midrst");
    rst_n = 1'b1;
    step("post_rst", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd7);

    step("bypass", 1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 4'd3, 4'd3);
    chk("bypass_const", rd1_0, 32'h12345678);

    step("rsv9", 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 4'd9, 4'd3);
    step("rsv9_again", 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 4'd9, 4'd9);
    chk("rsv9_cnt_const", 32'(cnt_0), 32'd1);
    step("wr9", 1'b1, 4'd9, 32'h000000A5, 1'b0, 4'd0, 4'd9, 4'd9);
    step("rd9", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd9, 4'd1);

    step("rsv_wr2", 1'b1, 4'd2, 32'h00000055, 1'b1, 4'd2, 4'd2, 4'd2);
    chk("rsv_wr2_busy_const", 32'(rb1_0), 32'd1);
    step("wr2_clear", 1'b1, 4'd2, 32'h00000066, 1'b0, 4'd0, 4'd2, 4'd0);

    step("r0", 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
    chk("r0_z1_const", rd1_1, 32'd0);
    chk("r0_z0_const", rd1_0, 32'hFFFFFFFF);
    step("r0_clear", 1'b1, 4'd0, 32'h0000ABCD, 1'b0, 4'd0, 4'd0, 4'd15);

    for (int i = 0; i < 16; i++) step("fill", 1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 4'(i), 4'(15 - i));
    chk("full_cnt16", 32'(cnt_0), 32'd16);
    for (int i = 0; i < 16; i++) step("drain", 1'b1, 4'(i), $urandom, 1'b0, 4'd0, 4'(i), 4'((i + 1) % 16));
    chk("drain_cnt0", 32'(cnt_0), 32'd0);

    for (int n = 0; n < 400; n++) begin
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
      step("rand", 1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra, a1, a2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
